// File: rtl/line_setup_unit.sv
// line_setup_unit
//   Bresenham line setup stage that sits directly in front of the fragment
//   generator. It accepts one segment per valid/ready handshake. It then runs
//   the steep test, the x/y swap and the endpoint ordering, and computes
//   |dx|, |dy| and ystep. Next it launches the fragment generator and holds
//   the framebuffer register enable until the generator reports finish.
//
//   Ports
//     clk, rst              clock; asynchronous active-low reset
//     line_valid/line_ready input handshake (ready only while idle)
//     x_a, y_a, x_b, y_b    segment endpoints (unsigned, WIDTH bits)
//     fg_finish             fragment generator has drawn the last x
//     start                 one-cycle launch pulse to the fragment generator
//     en_FB_reg             framebuffer register enable, high while drawing
//     steep, x0, y0, deltax, deltay, ystep, x_min, x_max
//                           registered geometry, updated only in CALC
//     busy                  high in any state other than IDLE
//     done                  one-cycle pulse when the line is complete
module line_setup_unit #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             line_valid,
  output logic             line_ready,
  input  logic [WIDTH-1:0] x_a,
  input  logic [WIDTH-1:0] y_a,
  input  logic [WIDTH-1:0] x_b,
  input  logic [WIDTH-1:0] y_b,
  input  logic             fg_finish,
  output logic             start,
  output logic             en_FB_reg,
  output logic             steep,
  output logic [WIDTH-1:0] x0,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] deltax,
  output logic [WIDTH-1:0] deltay,
  output logic [WIDTH-1:0] ystep,
  output logic [WIDTH-1:0] x_min,
  output logic [WIDTH-1:0] x_max,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SWAP, S_ORDER, S_CALC, S_START, S_DRAW, S_DONE
  } state_t;

  state_t state_reg, state_next;

  // Working copy of the endpoints; rewritten in place by SWAP and ORDER.
  logic [WIDTH-1:0] xa_reg, ya_reg, xb_reg, yb_reg;
  logic             steep_work_reg;

  // Registered geometry presented to the fragment generator.
  logic             steep_reg;
  logic [WIDTH-1:0] x0_reg, y0_reg, deltax_reg, deltay_reg, ystep_reg;
  logic [WIDTH-1:0] x_min_reg, x_max_reg;

  // One extra bit so that a full-span difference keeps its sign and the
  // magnitude (at most 2^WIDTH-1) never overflows.
  logic [WIDTH:0] dx_diff, dy_diff, dx_abs, dy_abs;

  always_comb begin
    dx_diff = {1'b0, xb_reg} - {1'b0, xa_reg};
    dy_diff = {1'b0, yb_reg} - {1'b0, ya_reg};
    dx_abs  = dx_diff[WIDTH] ? (~dx_diff + 1'b1) : dx_diff;
    dy_abs  = dy_diff[WIDTH] ? (~dy_diff + 1'b1) : dy_diff;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  // Next-state and control outputs
  always_comb begin
    state_next = state_reg;
    line_ready = 1'b0;
    start      = 1'b0;
    en_FB_reg  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        line_ready = 1'b1;
        busy       = 1'b0;
        if (line_valid) state_next = S_LOAD;
      end
      S_LOAD:  state_next = S_SWAP;
      S_SWAP:  state_next = S_ORDER;
      S_ORDER: state_next = S_CALC;
      S_CALC:  state_next = S_START;
      S_START: begin
        start      = 1'b1;
        en_FB_reg  = 1'b1;
        state_next = S_DRAW;
      end
      S_DRAW: begin
        en_FB_reg = 1'b1;
        if (fg_finish) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: each setup step owns exactly one state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xa_reg         <= '0;
      ya_reg         <= '0;
      xb_reg         <= '0;
      yb_reg         <= '0;
      steep_work_reg <= 1'b0;
      steep_reg      <= 1'b0;
      x0_reg         <= '0;
      y0_reg         <= '0;
      deltax_reg     <= '0;
      deltay_reg     <= '0;
      ystep_reg      <= '0;
      x_min_reg      <= '0;
      x_max_reg      <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (line_valid) begin
            xa_reg <= x_a;
            ya_reg <= y_a;
            xb_reg <= x_b;
            yb_reg <= y_b;
          end
        end
        S_LOAD: steep_work_reg <= (dy_abs > dx_abs);
        S_SWAP: begin
          if (steep_work_reg) begin
            xa_reg <= ya_reg;
            ya_reg <= xa_reg;
            xb_reg <= yb_reg;
            yb_reg <= xb_reg;
          end
        end
        S_ORDER: begin
          if (xa_reg > xb_reg) begin
            xa_reg <= xb_reg;
            ya_reg <= yb_reg;
            xb_reg <= xa_reg;
            yb_reg <= ya_reg;
          end
        end
        S_CALC: begin
          // Endpoints are ordered here, so xb_reg - xa_reg cannot wrap.
          steep_reg  <= steep_work_reg;
          x0_reg     <= xa_reg;
          y0_reg     <= ya_reg;
          deltax_reg <= xb_reg - xa_reg;
          deltay_reg <= (yb_reg >= ya_reg) ? (yb_reg - ya_reg) : (ya_reg - yb_reg);
          ystep_reg  <= (yb_reg >= ya_reg) ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b1}};
          x_min_reg  <= xa_reg;
          x_max_reg  <= xb_reg;
        end
        default: ;
      endcase
    end
  end

  assign steep  = steep_reg;
  assign x0     = x0_reg;
  assign y0     = y0_reg;
  assign deltax = deltax_reg;
  assign deltay = deltay_reg;
  assign ystep  = ystep_reg;
  assign x_min  = x_min_reg;
  assign x_max  = x_max_reg;

endmodule

// File: tb/tb_line_setup_unit.sv
// Directed testbench for line_setup_unit: hand-computed geometry for a set of
// segments, start latency, handshake behaviour and asynchronous reset.
module tb_line_setup_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       line_valid = 1'b0;
  logic       line_ready;
  logic [9:0] x_a = '0, y_a = '0, x_b = '0, y_b = '0;
  logic       fg_finish = 1'b0;
  logic       start, en_FB_reg, steep, busy, done;
  logic [9:0] x0, y0, deltax, deltay, ystep, x_min, x_max;

  int tests_run = 0;
  int tests_failed = 0;

  line_setup_unit #(.WIDTH(10)) dut (
    .clk(clk), .rst(rst),
    .line_valid(line_valid), .line_ready(line_ready),
    .x_a(x_a), .y_a(y_a), .x_b(x_b), .y_b(y_b),
    .fg_finish(fg_finish), .start(start), .en_FB_reg(en_FB_reg),
    .steep(steep), .x0(x0), .y0(y0), .deltax(deltax), .deltay(deltay),
    .ystep(ystep), .x_min(x_min), .x_max(x_max),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Packs the geometry outputs as {steep,x0,y0,deltax,deltay,ystep,x_min,x_max}.
  function automatic logic [70:0] geom();
    return {steep, x0, y0, deltax, deltay, ystep, x_min, x_max};
  endfunction

  // Presents a segment for one accepting edge and returns how many negedges
  // after that edge start was first seen (-1 if never within 20 cycles).
  task automatic send_line(input logic [9:0] xa, ya, xb, yb, output int lat);
    @(negedge clk);
    x_a = xa; y_a = ya; x_b = xb; y_b = yb;
    line_valid = 1'b1;
    @(posedge clk);
    #1 line_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (start) begin
        lat = n;
        break;
      end
    end
  endtask

  // Pulses fg_finish in DRAW; returns {done,en_FB_reg,busy,line_ready} in the
  // cycle after finish and in the cycle after that.
  task automatic finish_line(output logic [3:0] at_done, output logic [3:0] at_idle);
    @(negedge clk);
    fg_finish = 1'b1;
    @(negedge clk);
    fg_finish = 1'b0;
    at_done = {done, en_FB_reg, busy, line_ready};
    @(negedge clk);
    at_idle = {done, en_FB_reg, busy, line_ready};
  endtask

  task automatic test_reset;
    #3;
    tests_run++;
    if ({line_ready, start, en_FB_reg, busy, done} !== 5'b10000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b want 10000", {line_ready, start, en_FB_reg, busy, done});
    end
    tests_run++;
    if (geom() !== 71'd0) begin
      tests_failed++;
      $display("FAIL reset_geom: got %h want 0", geom());
    end
    @(negedge clk);
    rst = 1'b1;
    // fg_finish while idle must be ignored
    @(negedge clk);
    fg_finish = 1'b1;
    @(negedge clk);
    fg_finish = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({done, busy, line_ready} !== 3'b001) begin
      tests_failed++;
      $display("FAIL finish_in_idle: got %b want 001", {done, busy, line_ready});
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_basic;
    int lat;
    logic [3:0] a, b;
    send_line(10'd0, 10'd0, 10'd9, 10'd3, lat);
    tests_run++;
    if (lat !== 5) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d want 5", lat);
    end
    tests_run++;
    if (geom() !== {1'b0, 10'd0, 10'd0, 10'd9, 10'd3, 10'd1, 10'd0, 10'd9}) begin
      tests_failed++;
      $display("FAIL basic_geom: got %h", geom());
    end
    @(negedge clk);
    tests_run++;
    if ({start, en_FB_reg, busy, line_ready} !== 4'b0110) begin
      tests_failed++;
      $display("FAIL basic_draw: got %b want 0110", {start, en_FB_reg, busy, line_ready});
    end
    finish_line(a, b);
    tests_run++;
    if ({a, b} !== 8'b1010_0001) begin
      tests_failed++;
      $display("FAIL basic_finish: got %b want 10100001", {a, b});
    end
    tests_run++;
    if (geom() !== {1'b0, 10'd0, 10'd0, 10'd9, 10'd3, 10'd1, 10'd0, 10'd9}) begin
      tests_failed++;
      $display("FAIL basic_geom_held: got %h", geom());
    end
    $display("[TB] line (0,0)->(9,3) lat=%0d", lat);
  endtask

  task automatic test_reverse;
    int lat;
    logic [3:0] a, b;
    send_line(10'd9, 10'd3, 10'd0, 10'd0, lat);
    tests_run++;
    if (lat !== 5 || geom() !== {1'b0, 10'd0, 10'd0, 10'd9, 10'd3, 10'd1, 10'd0, 10'd9}) begin
      tests_failed++;
      $display("FAIL reverse: lat %0d geom %h want lat 5 geom of (0,0)->(9,3)", lat, geom());
    end
    finish_line(a, b);
    $display("[TB] line (9,3)->(0,0) lat=%0d", lat);
  endtask

  task automatic test_steep;
    int lat;
    logic [3:0] a, b;
    send_line(10'd5, 10'd2, 10'd1, 10'd8, lat);
    tests_run++;
    if (lat !== 5 || geom() !== {1'b1, 10'd2, 10'd5, 10'd6, 10'd4, 10'h3FF, 10'd2, 10'd8}) begin
      tests_failed++;
      $display("FAIL steep: lat %0d geom %h", lat, geom());
    end
    finish_line(a, b);
    $display("[TB] line (5,2)->(1,8) lat=%0d", lat);
  endtask

  task automatic test_point;
    int lat;
    logic [3:0] a, b;
    send_line(10'd4, 10'd4, 10'd4, 10'd4, lat);
    tests_run++;
    if (lat !== 5 || geom() !== {1'b0, 10'd4, 10'd4, 10'd0, 10'd0, 10'd1, 10'd4, 10'd4}) begin
      tests_failed++;
      $display("FAIL point: lat %0d geom %h", lat, geom());
    end
    repeat (5) @(negedge clk);
    tests_run++;
    if ({done, en_FB_reg, busy, line_ready} !== 4'b0110) begin
      tests_failed++;
      $display("FAIL point_wait: got %b want 0110", {done, en_FB_reg, busy, line_ready});
    end
    finish_line(a, b);
    tests_run++;
    if ({a, b} !== 8'b1010_0001) begin
      tests_failed++;
      $display("FAIL point_finish: got %b want 10100001", {a, b});
    end
    $display("[TB] line (4,4)->(4,4) lat=%0d", lat);
  endtask

  task automatic test_max_span;
    int lat;
    logic [3:0] a, b;
    // |dx|==|dy|: not steep, descending y
    send_line(10'd0, 10'd1023, 10'd1023, 10'd0, lat);
    tests_run++;
    if (lat !== 5 || geom() !== {1'b0, 10'd0, 10'd1023, 10'd1023, 10'd1023, 10'h3FF, 10'd0, 10'd1023}) begin
      tests_failed++;
      $display("FAIL max_diag: lat %0d geom %h", lat, geom());
    end
    finish_line(a, b);
    // steep full span needing both swap and reorder
    send_line(10'd1, 10'd1023, 10'd0, 10'd0, lat);
    tests_run++;
    if (lat !== 5 || geom() !== {1'b1, 10'd0, 10'd0, 10'd1023, 10'd1, 10'd1, 10'd0, 10'd1023}) begin
      tests_failed++;
      $display("FAIL max_steep: lat %0d geom %h", lat, geom());
    end
    finish_line(a, b);
    $display("[TB] max span lines lat=%0d", lat);
  endtask

  task automatic test_back_to_back;
    int starts;
    int lat2;
    @(negedge clk);
    x_a = 10'd0; y_a = 10'd0; x_b = 10'd9; y_b = 10'd3;
    line_valid = 1'b1;
    starts = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (start) starts++;
    end
    tests_run++;
    if (starts !== 1 || {busy, line_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL b2b_hold: starts %0d busy/ready %b want 1 and 10", starts, {busy, line_ready});
    end
    // finish and still-valid line arrive together in DRAW
    fg_finish = 1'b1;
    x_a = 10'd5; y_a = 10'd2; x_b = 10'd1; y_b = 10'd8;
    @(negedge clk);
    fg_finish = 1'b0;
    tests_run++;
    if ({done, line_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL b2b_done: got %b want 10", {done, line_ready});
    end
    @(negedge clk);
    tests_run++;
    if (line_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_ready: got %b want 1", line_ready);
    end
    lat2 = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (start) begin
        lat2 = n;
        break;
      end
    end
    line_valid = 1'b0;
    tests_run++;
    if (lat2 !== 5 || geom() !== {1'b1, 10'd2, 10'd5, 10'd6, 10'd4, 10'h3FF, 10'd2, 10'd8}) begin
      tests_failed++;
      $display("FAIL b2b_second: lat %0d geom %h", lat2, geom());
    end
    starts = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (start) starts++;
    end
    tests_run++;
    if (starts !== 0) begin
      tests_failed++;
      $display("FAIL b2b_extra_start: got %0d want 0", starts);
    end
    begin
      logic [3:0] a, b;
      finish_line(a, b);
    end
    $display("[TB] back-to-back lines second lat=%0d", lat2);
  endtask

  task automatic test_async_reset;
    int lat;
    logic [3:0] a, b;
    send_line(10'd5, 10'd2, 10'd1, 10'd8, lat);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if ({line_ready, start, en_FB_reg, busy, done} !== 5'b10000 || geom() !== 71'd0) begin
      tests_failed++;
      $display("FAIL async_reset: ctrl %b geom %h want 10000 and 0",
               {line_ready, start, en_FB_reg, busy, done}, geom());
    end
    @(negedge clk);
    rst = 1'b1;
    send_line(10'd0, 10'd0, 10'd9, 10'd3, lat);
    tests_run++;
    if (lat !== 5 || geom() !== {1'b0, 10'd0, 10'd0, 10'd9, 10'd3, 10'd1, 10'd0, 10'd9}) begin
      tests_failed++;
      $display("FAIL post_reset_line: lat %0d geom %h", lat, geom());
    end
    finish_line(a, b);
    tests_run++;
    if ({a, b} !== 8'b1010_0001) begin
      tests_failed++;
      $display("FAIL post_reset_finish: got %b want 10100001", {a, b});
    end
    $display("[TB] async reset mid-draw, relaunch lat=%0d", lat);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reverse();
    test_steep();
    test_point();
    test_max_span();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
